// File: rtl/free_list_if.sv
// Rename-stage free list bus: allocation, release, retire and restore
// signals shared between the rename/retire logic and the free list.
interface free_list_if #(
  parameter int NUM_PREGS = 64,
  parameter int PR_W      = $clog2(NUM_PREGS),
  parameter int PTR_W     = PR_W + 1
);
  logic             alloc_req;
  logic             alloc_valid;
  logic [PR_W-1:0]  alloc_pr_idx;
  logic             retire_alloc;
  logic             free_enable;
  logic [PR_W-1:0]  free_pr_idx;
  logic             restore_enable;
  logic [PTR_W-1:0] free_count;
  logic             empty;
  logic             err;

  // Rename / retire side.
  modport master (
    output alloc_req, retire_alloc, free_enable, free_pr_idx, restore_enable,
    input  alloc_valid, alloc_pr_idx, free_count, empty, err
  );

  // Free list side.
  modport slave (
    input  alloc_req, retire_alloc, free_enable, free_pr_idx, restore_enable,
    output alloc_valid, alloc_pr_idx, free_count, empty, err
  );
endinterface

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of free preg indices with a
// speculative head (allocation), a retired head (commit boundary) and a tail
// (released pregs). A mispredict restore snaps the speculative head back to
// the retired head, returning all speculative allocations in one cycle.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int PR_W      = $clog2(NUM_PREGS),
  parameter int PTR_W     = PR_W + 1
) (
  input logic        clk,
  input logic        reset,
  free_list_if.slave fl
);

  logic [PR_W-1:0]  buf_r [NUM_PREGS];
  logic [PTR_W-1:0] spec_head_r;
  logic [PTR_W-1:0] ret_head_r;
  logic [PTR_W-1:0] tail_r;
  logic             err_r;

  logic [PTR_W-1:0] count_s;
  logic             full_s;
  logic             alloc_fire_s;
  logic             push_req_s;
  logic             push_fire_s;
  logic             retire_bad_s;
  logic [PTR_W-1:0] ret_head_next_s;
  logic [PTR_W-1:0] spec_head_next_s;
  logic [PTR_W-1:0] tail_next_s;
  logic             err_next_s;

  // Occupancy seen by rename, and physical fullness measured from the retired
  // head so that speculatively allocated entries are never overwritten.
  assign count_s = tail_r - spec_head_r;
  assign full_s  = ((tail_r - ret_head_r) == PTR_W'(NUM_PREGS));

  // Zero-latency read at the speculative head.
  assign fl.alloc_valid  = (count_s != {PTR_W{1'b0}});
  assign fl.alloc_pr_idx = buf_r[spec_head_r[PR_W-1:0]];
  assign fl.free_count   = count_s;
  assign fl.empty        = (count_s == {PTR_W{1'b0}});
  assign fl.err          = err_r;

  // Next-pointer and error computation; restore beats a same-cycle allocate
  // but still lands on the retired head including a same-cycle retire.
  always_comb begin
    alloc_fire_s     = 1'b0;
    push_req_s       = 1'b0;
    push_fire_s      = 1'b0;
    retire_bad_s     = 1'b0;
    ret_head_next_s  = ret_head_r;
    spec_head_next_s = spec_head_r;
    tail_next_s      = tail_r;
    err_next_s       = err_r;

    push_req_s  = fl.free_enable && (fl.free_pr_idx != {PR_W{1'b0}});
    push_fire_s = push_req_s && !full_s;

    if (push_fire_s) begin
      tail_next_s = tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      tail_next_s = tail_r;
    end

    if (fl.retire_alloc) begin
      if (ret_head_r == spec_head_r) begin
        retire_bad_s    = 1'b1;
        ret_head_next_s = ret_head_r;
      end else begin
        retire_bad_s    = 1'b0;
        ret_head_next_s = ret_head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      retire_bad_s    = 1'b0;
      ret_head_next_s = ret_head_r;
    end

    if (fl.restore_enable) begin
      alloc_fire_s     = 1'b0;
      spec_head_next_s = ret_head_next_s;
    end else if (fl.alloc_req && fl.alloc_valid) begin
      alloc_fire_s     = 1'b1;
      spec_head_next_s = spec_head_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      alloc_fire_s     = 1'b0;
      spec_head_next_s = spec_head_r;
    end

    if ((push_req_s && full_s) || retire_bad_s) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = err_r;
    end
  end

  // State update; reset reloads pregs 1..NUM_PREGS-1 and drops any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        buf_r[i] <= (i < NUM_PREGS - 1) ? PR_W'(i + 1) : {PR_W{1'b0}};
      end
      spec_head_r <= {PTR_W{1'b0}};
      ret_head_r  <= {PTR_W{1'b0}};
      tail_r      <= PTR_W'(NUM_PREGS - 1);
      err_r       <= 1'b0;
    end else begin
      if (push_fire_s) begin
        buf_r[tail_r[PR_W-1:0]] <= fl.free_pr_idx;
      end
      spec_head_r <= spec_head_next_s;
      ret_head_r  <= ret_head_next_s;
      tail_r      <= tail_next_s;
      err_r       <= err_next_s;
    end
  end

`ifdef DEBUG_PRINT
  // Pointer trace once per cycle on the inactive clock edge.
  always @(negedge clk) begin
    $display("free_list: spec_head=%0d ret_head=%0d tail=%0d free_count=%0d",
             spec_head_r, ret_head_r, tail_r, count_s);
  end
`endif

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical register free list for the rename stage: the producer side of the map table's new_dest_pr_idx path, and the consumer of old destination pregs released at retire.
- It is a circular FIFO of free physical register indices with three pointers:
  - spec head: next index to hand out.
  - retired head: boundary of committed allocations.
  - tail: next slot to write a freed index into.
- On mispredict restore, the spec head snaps back to the retired head, returning every speculatively allocated preg in one cycle.

Parameters:
- NUM_PREGS, 64, physical register count and FIFO depth; must be a power of two.
- PR_W, $clog2(NUM_PREGS), preg index width.
- PTR_W, PR_W+1, pointer width (index plus wrap bit).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- alloc_req  in  1  rename wants a new dest preg this cycle.
- alloc_valid  out  1  list non-empty; alloc_pr_idx is valid.
- alloc_pr_idx  out  PR_W  index at spec head; drives map table new_dest_pr_idx.
- retire_alloc  in  1  the retiring instruction had allocated a dest preg; advances the retired head.
- free_enable  in  1  push a released preg (old dest of the retiring instruction).
- free_pr_idx  in  PR_W  preg to release.
- restore_enable  in  1  mispredict squash; roll the spec head back.
- free_count  out  PTR_W  tail minus spec head.
- empty  out  1  free_count==0.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Storage: NUM_PREGS entries of PR_W bits. Pointers are PTR_W wide and compare with the wrap bit. Storage index is ptr[PR_W-1:0].
- Reset (synchronous, all state), for all i in 0..NUM_PREGS-2:
  - buf[i]=i+1; spec_head=0; ret_head=0; tail=NUM_PREGS-1; err=0.
  - Outputs after reset: alloc_valid=1, alloc_pr_idx=1, free_count=NUM_PREGS-1, empty=0.
  - Preg 0 is never in the list.
  - Reset mid-operation discards all state and discards any same-cycle request.
- alloc_valid and alloc_pr_idx are combinational from spec_head and tail. Zero-latency read.
- There is no bypass from free to alloc: a preg freed in cycle N is allocatable in cycle N+1 at the earliest.
- Allocate: alloc_req && alloc_valid at posedge -> spec_head+1. alloc_req while empty is ignored; no error is raised, and rename must stall.
- Free: free_enable && free_pr_idx!=0 -> buf[tail]=free_pr_idx; tail+1.
  - free_pr_idx==0 is silently ignored (zero reg / reset mapping).
  - If tail-ret_head==NUM_PREGS (physically full), the push is dropped and err is set.
- Retire: retire_alloc -> ret_head+1.
  - If ret_head==spec_head, the retire is ignored and err is set.
- Restore: restore_enable -> spec_head <= ret_head_next, where ret_head_next includes any same-cycle retire_alloc increment.
  - Restore overrides a same-cycle allocate; that alloc is not granted.
  - A same-cycle free is still performed, because it belongs to an older, committing instruction.
- Entries between ret_head and spec_head must not be overwritten; the full check against ret_head guarantees this.
- Simultaneous alloc+free (no restore): both take effect, free_count unchanged. This is legal even when free_count==1.
- Wrap-around: all pointers wrap modulo 2*NUM_PREGS with no special casing.
- err stays set until reset.
- Debug: at negedge under DEBUG_PRINT, print spec_head, ret_head, tail and free_count.

Test Plan:
- Reset, then alloc_req for 3 cycles -> alloc_pr_idx 1,2,3 granted; free_count 63->60; alloc_valid stays 1.
- Allocate 63 times -> empty=1, alloc_valid=0, free_count=0. Further alloc_req is ignored; err=0.
- From empty: free_enable with idx 5 -> next cycle alloc_valid=1, alloc_pr_idx=5. The same-cycle alloc_req while empty is not granted.
- Allocate 4 (pregs 1..4) and retire_alloc once, then restore_enable -> next alloc_pr_idx=2, free_count=62. Restore with simultaneous retire_alloc -> next alloc_pr_idx=3.
- free_pr_idx=0 with free_enable -> free_count unchanged, err=0. Push while tail-ret_head==64 -> dropped, err=1. retire_alloc with ret_head==spec_head -> err=1.
- Reset asserted mid-sequence with alloc_req, free_enable and restore_enable all high -> next cycle alloc_pr_idx=1, free_count=63, err=0.
